pce_video_capture: RTL and testbench

Pixel-stream receiver for the HuC6260 VCE video output. Samples the 9-bit RGB333 pixel stream and active-low HSYNC_n/VSYNC_n on every `clock_en` tick and tracks horizontal/vertical position from the sync falling edges. Writes a programmable active window into a linear framebuffer through a one-cycle write strobe, and reports measured line length and lines per frame. Sits between the VCE and the scan-converter framebuffer/scaler path.

---
 rtl/pce_video_capture.sv | 161 ++++++++++++++++
 tb/tb_pce_video_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pce_video_capture.sv
// rtl/pce_video_capture.sv - HuC6260 VCE pixel-stream capture into a linear framebuffer
// Tracks sync position per clock_en tick and writes a programmable window with a one-cycle strobe.
module pce_video_capture #(
  parameter int H_OFFSET = 32,
  parameter int H_ACTIVE = 256,
  parameter int V_OFFSET = 16,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_en,
  input  logic [2:0]        VIDEO_R,
  input  logic [2:0]        VIDEO_G,
  input  logic [2:0]        VIDEO_B,
  input  logic              HSYNC_n,
  input  logic              VSYNC_n,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [8:0]        fb_data,
  output logic              fb_we,
  output logic              frame_start,
  output logic              frame_done,
  output logic [11:0]       line_len,
  output logic [9:0]        frame_lines,
  output logic              sync_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE} state_t;

  localparam logic [12:0]       H_LO      = 13'(H_OFFSET);
  localparam logic [12:0]       H_HI      = 13'(H_OFFSET + H_ACTIVE);
  localparam logic [10:0]       V_LO      = 11'(V_OFFSET);
  localparam logic [10:0]       V_HI      = 11'(V_OFFSET + V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state_q;
  logic              primed_q;
  logic              prev_h_q;
  logic              prev_v_q;
  logic [11:0]       h_cnt_q;
  logic [11:0]       h_cnt_d;
  logic [9:0]        v_cnt_q;
  logic [9:0]        v_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_d;
  logic              full_q;
  logic              full_d;
  logic              hfall;
  logic              vfall;
  logic              h_hit_max;
  logic              in_win;

  logic [ADDR_W-1:0] fb_addr_q;
  logic [8:0]        fb_data_q;
  logic              fb_we_q;
  logic              frame_start_q;
  logic              frame_done_q;
  logic [11:0]       line_len_q;
  logic [9:0]        frame_lines_q;
  logic              sync_err_q;

  // primed_q masks the first tick after reset so a sync already low is not an edge
  always_comb begin
    hfall   = primed_q & prev_h_q & ~HSYNC_n;
    vfall   = primed_q & prev_v_q & ~VSYNC_n;
    h_cnt_d = hfall ? 12'd0 : ((&h_cnt_q) ? h_cnt_q : h_cnt_q + 12'd1);
    v_cnt_d = v_cnt_q;
    if (vfall) begin
      v_cnt_d = 10'd0;
    end else if (hfall && !(&v_cnt_q)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end
    h_hit_max = (&h_cnt_d) & ~(&h_cnt_q);
    in_win = (state_q == ST_ACTIVE) &&
             ({1'b0, h_cnt_d} >= H_LO) && ({1'b0, h_cnt_d} < H_HI) &&
             ({1'b0, v_cnt_d} >= V_LO) && ({1'b0, v_cnt_d} < V_HI);
    wr_cnt_d = vfall ? '0 : wr_cnt_q;
    full_d   = vfall ? 1'b0 : full_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      primed_q      <= 1'b0;
      prev_h_q      <= 1'b1;
      prev_v_q      <= 1'b1;
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 10'd0;
      wr_cnt_q      <= '0;
      full_q        <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= 9'd0;
      fb_we_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_len_q    <= 12'd0;
      frame_lines_q <= 10'd0;
      sync_err_q    <= 1'b0;
    end else begin
      fb_we_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      if (clock_en) begin
        primed_q      <= 1'b1;
        prev_h_q      <= HSYNC_n;
        prev_v_q      <= VSYNC_n;
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        frame_start_q <= vfall;

        if (h_hit_max) begin
          sync_err_q <= 1'b1;
          state_q    <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE:   if (vfall) state_q <= hfall ? ST_ACTIVE : ST_ARMED;
            ST_ARMED:  if (hfall) state_q <= ST_ACTIVE;
            ST_ACTIVE: state_q <= ST_ACTIVE;
            default:   state_q <= ST_IDLE;
          endcase
        end

        if (state_q == ST_ACTIVE && hfall) begin
          line_len_q <= (&h_cnt_q) ? 12'hFFF : h_cnt_q + 12'd1;
        end
        if (state_q == ST_ACTIVE && vfall) begin
          frame_lines_q <= (&v_cnt_q) ? 10'h3FF : v_cnt_q + 10'd1;
        end

        // Once the last address is written the counter parks until the next vfall
        if (in_win && !full_d) begin
          fb_we_q   <= 1'b1;
          fb_addr_q <= wr_cnt_d;
          fb_data_q <= {VIDEO_R, VIDEO_G, VIDEO_B};
          if (wr_cnt_d == LAST_ADDR) begin
            full_q       <= 1'b1;
            frame_done_q <= 1'b1;
            wr_cnt_q     <= wr_cnt_d;
          end else begin
            full_q   <= 1'b0;
            wr_cnt_q <= wr_cnt_d + ADDR_W'(1);
          end
        end else begin
          wr_cnt_q <= wr_cnt_d;
          full_q   <= full_d;
        end
      end
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign fb_we       = fb_we_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_pce_video_capture.sv
// tb/tb_pce_video_capture.sv - randomized-pixel bench for pce_video_capture with a geometric window model
module tb_pce_video_capture;

  localparam int HO   = 2;
  localparam int HA   = 4;
  localparam int VO   = 1;
  localparam int VA   = 2;
  localparam int LLEN = 10;
  localparam int NL   = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic [2:0]  VIDEO_R, VIDEO_G, VIDEO_B;
  logic        HSYNC_n, VSYNC_n;
  logic [15:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_we, frame_start, frame_done, sync_err;
  logic [11:0] line_len;
  logic [9:0]  frame_lines;

  always #5 clock = ~clock;

  pce_video_capture #(
    .H_OFFSET(HO), .H_ACTIVE(HA), .V_OFFSET(VO), .V_ACTIVE(VA), .ADDR_W(16)
  ) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .frame_start(frame_start), .frame_done(frame_done),
    .line_len(line_len), .frame_lines(frame_lines), .sync_err(sync_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // expected writes as {addr, data}, derived from line/pixel position in the window
  logic [24:0] exp_q[$];
  bit   mon_en    = 1'b0;
  bit   gate_mode = 1'b0;
  bit   prev_we   = 1'b0;
  int   n_we = 0, n_start = 0, n_done = 0, n_err = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (fb_we === 1'b1) begin
        n_we++;
        if (gate_mode) check_eq("we_one_cycle", 32'(prev_we), 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_we", 32'(fb_we), 0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          check_eq("fb_addr", 32'(fb_addr), 32'(e[24:9]));
          check_eq("fb_data", 32'(fb_data), 32'(e[8:0]));
          check_eq("frame_done", 32'(frame_done), 32'(e[24:9] == 16'(HA * VA - 1)));
        end
      end else if (frame_done === 1'b1) begin
        check_eq("frame_done_without_we", 32'(frame_done), 0);
      end
      if (frame_start === 1'b1) n_start++;
      if (frame_done === 1'b1) n_done++;
      if (sync_err === 1'b1) n_err++;
      prev_we = (fb_we === 1'b1);
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic [8:0] pix, input int period);
    @(negedge clock);
    HSYNC_n  = hs;
    VSYNC_n  = vs;
    {VIDEO_R, VIDEO_G, VIDEO_B} = pix;
    clock_en = 1'b1;
    for (int i = 1; i < period; i++) begin
      @(negedge clock);
      clock_en = 1'b0;
    end
  endtask

  // wl: window line index for expectations (-1 = none); vt: tick where VSYNC falls (-1 = none)
  task automatic drive_line(input int wl, input int vt, input int period, input int t0, input int t1);
    logic [8:0] pix;
    for (int t = t0; t <= t1; t++) begin
      pix = 9'($urandom_range(0, 511));
      if (wl >= VO && wl < VO + VA && t >= HO && t < HO + HA)
        exp_q.push_back({16'((wl - VO) * HA + (t - HO)), pix});
      tick(logic'(t >= 2), logic'(!(vt >= 0 && t >= vt)), pix, period);
    end
  endtask

  task automatic drive_frame(input int period);
    for (int l = 0; l < NL; l++) drive_line(l, (l == 0) ? 0 : -1, period, 0, LLEN - 1);
  endtask

  task automatic settle();
    @(negedge clock);
    clock_en = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset    = 1'b1;
    clock_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int we0, err0;
    reset    = 1'b1;
    clock_en = 1'b1;
    HSYNC_n  = 1'b0;
    VSYNC_n  = 1'b0;
    {VIDEO_R, VIDEO_G, VIDEO_B} = 9'd0;

    // reset hygiene: syncs low through reset release
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 9'($urandom_range(0, 511)), 1);
    settle();
    check_eq("rst_we_count", n_we, 0);
    check_eq("rst_frame_start", n_start, 0);
    check_eq("rst_frame_done", n_done, 0);
    check_eq("rst_sync_err", n_err, 0);
    check_eq("rst_fb_addr", 32'(fb_addr), 0);
    check_eq("rst_fb_data", 32'(fb_data), 0);
    check_eq("rst_line_len", 32'(line_len), 0);
    check_eq("rst_frame_lines", 32'(frame_lines), 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 9'd0, 1);

    // basic capture, two frames back to back
    drive_frame(1);
    settle();
    check_eq("f1_pending", exp_q.size(), 0);
    check_eq("f1_writes", n_we, 8);
    check_eq("f1_line_len", 32'(line_len), LLEN);
    check_eq("f1_frame_start", n_start, 1);
    check_eq("f1_frame_done", n_done, 1);
    drive_frame(1);
    settle();
    check_eq("f2_pending", exp_q.size(), 0);
    check_eq("f2_writes", n_we, 16);
    check_eq("f2_frame_lines", 32'(frame_lines), NL);
    check_eq("f2_frame_start", n_start, 2);

    // clock_en gated 1 in 3
    gate_mode = 1'b1;
    drive_frame(3);
    settle();
    gate_mode = 1'b0;
    check_eq("gate_pending", exp_q.size(), 0);
    check_eq("gate_writes", n_we, 24);
    check_eq("gate_frame_done", n_done, 3);

    // VSYNC falling mid-line at tick 6 of line 3
    drive_line(0, 0, 1, 0, LLEN - 1);
    drive_line(1, -1, 1, 0, LLEN - 1);
    drive_line(2, -1, 1, 0, LLEN - 1);
    drive_line(-1, 6, 1, 0, LLEN - 1);
    settle();
    check_eq("mid_frame_lines", 32'(frame_lines), 4);
    for (int l = 1; l < NL; l++) drive_line(l, -1, 1, 0, LLEN - 1);
    settle();
    check_eq("mid_pending", exp_q.size(), 0);
    drive_frame(1);
    settle();
    check_eq("mid_next_frame_lines", 32'(frame_lines), NL);
    check_eq("mid_line_len", 32'(line_len), LLEN);
    check_eq("mid_pending2", exp_q.size(), 0);

    // HSYNC loss while ACTIVE
    err0 = n_err;
    drive_line(0, 0, 1, 0, LLEN - 1);
    drive_line(1, -1, 1, 0, LLEN - 1);
    for (int i = 0; i < 4100; i++) tick(1'b1, 1'b1, 9'($urandom_range(0, 511)), 1);
    settle();
    check_eq("loss_sync_err", n_err - err0, 1);
    we0 = n_we;
    drive_line(-1, -1, 1, 0, LLEN - 1);
    drive_line(-1, -1, 1, 0, LLEN - 1);
    settle();
    check_eq("loss_no_writes", n_we - we0, 0);
    drive_frame(1);
    settle();
    check_eq("loss_recover_writes", n_we - we0, 8);
    check_eq("loss_pending", exp_q.size(), 0);
    check_eq("loss_sync_err_once", n_err - err0, 1);

    // reset after the third write of a frame
    we0 = n_we;
    drive_line(0, 0, 1, 0, LLEN - 1);
    drive_line(1, -1, 1, 0, 4);
    pulse_reset();
    check_eq("mrst_fb_addr", 32'(fb_addr), 0);
    check_eq("mrst_fb_we", 32'(fb_we), 0);
    check_eq("mrst_writes", n_we - we0, 3);
    drive_line(-1, -1, 1, 5, LLEN - 1);
    for (int l = 2; l < NL; l++) drive_line(-1, -1, 1, 0, LLEN - 1);
    settle();
    check_eq("mrst_no_writes", n_we - we0, 3);
    drive_frame(1);
    settle();
    check_eq("mrst_resume_writes", n_we - we0, 11);
    check_eq("mrst_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
